// File: rtl/dff_delay_line.sv
// rtl/dff_delay_line.sv - stallable, flushable WIDTH x DEPTH registered delay line
// Valid travels with data; outputs are a runtime-selected tap plus occupancy.
module dff_delay_line #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_d,
  input  logic [TAP_W-1:0] i_tap,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic             o_tap_err,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_s [DEPTH];
  logic [DEPTH-1:0] r_v;

  logic [WIDTH-1:0] w_q;
  logic             w_valid;
  logic             w_tap_err;
  logic [CNT_W-1:0] w_count;

  // Flush wins over enable; invalid entries still shift so latency stays fixed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_s[k] <= '0;
      end
      r_v <= '0;
    end else if (i_flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_s[k] <= '0;
      end
      r_v <= '0;
    end else if (i_en) begin
      r_s[0] <= i_d;
      r_v[0] <= i_valid;
      for (int k = 1; k < DEPTH; k++) begin
        r_s[k] <= r_s[k-1];
        r_v[k] <= r_v[k-1];
      end
    end
  end

  // Tap values with no matching stage fall through to the error defaults.
  always_comb begin
    w_q       = '0;
    w_valid   = 1'b0;
    w_tap_err = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_tap == TAP_W'(k)) begin
        w_q       = r_s[k];
        w_valid   = r_v[k];
        w_tap_err = 1'b0;
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + CNT_W'(r_v[k]);
    end
  end

  assign o_q       = w_q;
  assign o_valid   = w_valid;
  assign o_tap_err = w_tap_err;
  assign o_count   = w_count;

endmodule
